// File: rtl/ir_carrier_detector.sv
// IR carrier detector: measures the rise-to-rise period of the incoming
// carrier, classifies it into one of three bins and locks after a run of
// consecutive matching periods. The status LED is active-low.
module ir_carrier_detector #(
  parameter int PER_A    = 800,
  parameter int PER_B    = 600,
  parameter int PER_C    = 400,
  parameter int TOL      = 40,
  parameter int LOCK_CNT = 8,
  parameter int MISS_MAX = 3,
  parameter int TIMEOUT  = 4000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_in,
  output logic [15:0] period_meas,
  output logic        period_valid,
  output logic [1:0]  freq_code,
  output logic        locked,
  output logic        led
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACQ  = 2'd1,
    S_LOCK = 2'd2
  } state_t;

  localparam logic [15:0] LOCK16 = 16'(LOCK_CNT);
  localparam logic [15:0] MISS16 = 16'(MISS_MAX);
  localparam logic [15:0] TO16   = 16'(TIMEOUT - 1);

  logic        s1_q, s2_q, s3_q;
  logic        rise;
  logic [15:0] cnt_q;
  logic        armed_q;
  state_t      state_q;
  logic [1:0]  cand_q;
  logic [15:0] match_q;
  logic [15:0] miss_q;
  logic [15:0] period_q;
  logic [15:0] period_d;
  logic        pvalid_q;
  logic [1:0]  freq_q;
  logic        led_q;
  logic [1:0]  bin;

  // Inclusive tolerance window around a nominal period.
  function automatic logic in_win(input logic [15:0] p, input int nom);
    int d;
    d = int'(p) - nom;
    return (d <= TOL) && (d >= -TOL);
  endfunction

  // Two-stage synchronizer plus a delay flop for edge detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= rx_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise     = s2_q & ~s3_q;
  assign period_d = cnt_q + 16'd1;

  // Classify the candidate period; bins are tried in order A, B, C.
  always_comb begin
    bin = 2'd0;
    if (in_win(period_d, PER_A))      bin = 2'd1;
    else if (in_win(period_d, PER_B)) bin = 2'd2;
    else if (in_win(period_d, PER_C)) bin = 2'd3;
  end

  // Period counter, measurement, lock FSM and timeout; all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q    <= '0;
      armed_q  <= 1'b0;
      state_q  <= S_IDLE;
      cand_q   <= '0;
      match_q  <= '0;
      miss_q   <= '0;
      period_q <= '0;
      pvalid_q <= 1'b0;
      freq_q   <= '0;
      led_q    <= 1'b1;
    end else begin
      pvalid_q <= 1'b0;
      led_q    <= ~(state_q == S_LOCK);
      if (rise) begin
        cnt_q <= '0;
        if (!armed_q) begin
          armed_q <= 1'b1;
          state_q <= S_ACQ;
        end else begin
          period_q <= period_d;
          pvalid_q <= 1'b1;
          case (state_q)
            S_ACQ: begin
              if (bin != 2'd0 && bin == cand_q) begin
                match_q <= match_q + 16'd1;
                if (match_q + 16'd1 == LOCK16) begin
                  state_q <= S_LOCK;
                  freq_q  <= cand_q;
                  miss_q  <= '0;
                end
              end else begin
                cand_q  <= bin;
                match_q <= (bin != 2'd0) ? 16'd1 : 16'd0;
                // A lock count of one locks on the first in-band period.
                if (bin != 2'd0 && LOCK16 == 16'd1) begin
                  state_q <= S_LOCK;
                  freq_q  <= bin;
                  miss_q  <= '0;
                end
              end
            end
            S_LOCK: begin
              if (bin == freq_q) begin
                miss_q <= '0;
              end else begin
                miss_q <= miss_q + 16'd1;
                if (miss_q + 16'd1 == MISS16) begin
                  state_q <= S_ACQ;
                  freq_q  <= '0;
                  cand_q  <= bin;
                  match_q <= (bin != 2'd0) ? 16'd1 : 16'd0;
                end
              end
            end
            default: ;
          endcase
        end
      end else begin
        if (cnt_q != '1) cnt_q <= cnt_q + 16'd1;
        if (cnt_q == TO16) begin
          state_q <= S_IDLE;
          armed_q <= 1'b0;
          cand_q  <= '0;
          match_q <= '0;
          miss_q  <= '0;
          freq_q  <= '0;
        end
      end
    end
  end

  assign period_meas  = period_q;
  assign period_valid = pvalid_q;
  assign freq_code    = freq_q;
  assign locked       = (state_q == S_LOCK);
  assign led          = led_q;

endmodule
